// File: rtl/uart_apb_master.sv
`default_nettype none
// ============================================================================
// Module      : uart_apb_master
// Description : Single-transfer APB initiator for the UART register block.
//               Request/response front end, pready wait with optional timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_apb_master #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [11:0] apb_paddr,
  output logic        apb_psel,
  output logic        apb_penable,
  output logic        apb_pwrite,
  output logic [31:0] apb_pwdata,
  input  logic        apb_pready,
  input  logic [31:0] apb_prdata,
  input  logic        apb_pslverr
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // The counter holds the number of ACCESS cycles already completed, so the
  // timeout fires during the N-th ACCESS cycle.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      assign tmo_hit = (tmo_cnt == CNT_LAST);
    end else begin : g_no_timeout
      assign tmo_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (apb_pready || tmo_hit) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready   = (state == IDLE) && !reset;
  assign apb_psel    = (state == SETUP) || (state == ACCESS);
  assign apb_penable = (state == ACCESS);
  assign rsp_valid   = (state == RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      apb_paddr   <= 12'h000;
      apb_pwrite  <= 1'b0;
      apb_pwdata  <= 32'h0;
      rsp_rdata   <= 32'h0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        apb_paddr  <= req_addr;
        apb_pwrite <= req_write;
        apb_pwdata <= req_wdata;
        tmo_cnt    <= '0;
      end
      if (state == ACCESS) begin
        if (tmo_cnt != CNT_MAX) tmo_cnt <= tmo_cnt + CNT_W'(1);
        if (apb_pready) begin
          rsp_rdata   <= apb_pwrite ? 32'h0 : apb_prdata;
          rsp_err     <= apb_pslverr;
          rsp_timeout <= 1'b0;
        end else if (tmo_hit) begin
          rsp_rdata   <= 32'h0;
          rsp_err     <= 1'b1;
          rsp_timeout <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_apb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_apb_master
// Description : Directed, table-driven bench for uart_apb_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_apb_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [11:0] apb_paddr;
  logic        apb_psel, apb_penable, apb_pwrite;
  logic [31:0] apb_pwdata;
  logic        apb_pready;
  logic [31:0] apb_prdata;
  logic        apb_pslverr;

  // Slave model: raises pready after slave_wait stalled ACCESS cycles.
  int          slave_wait;
  int          acc_cnt;
  logic [31:0] slave_prdata;
  logic        slave_err;
  logic        force_pready;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        write;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_lat;
    int          exp_acc;
  } vec_t;

  vec_t vecs[7];

  uart_apb_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .apb_paddr   (apb_paddr),
    .apb_psel    (apb_psel),
    .apb_penable (apb_penable),
    .apb_pwrite  (apb_pwrite),
    .apb_pwdata  (apb_pwdata),
    .apb_pready  (apb_pready),
    .apb_prdata  (apb_prdata),
    .apb_pslverr (apb_pslverr)
  );

  always #5 clk = ~clk;

  assign apb_pready  = force_pready || (apb_psel && apb_penable && (acc_cnt >= slave_wait));
  assign apb_prdata  = slave_prdata;
  assign apb_pslverr = slave_err;

  always @(posedge clk) begin
    if (reset || !(apb_psel && apb_penable) || apb_pready) acc_cnt <= 0;
    else acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents a request at #1 after an edge and returns #1 after the accepting edge.
  task automatic issue(input logic wr, input logic [11:0] addr, input logic [31:0] wdata);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, {31'b0, rsp_valid}, 32'h0);
    check({tag, "_ready_back"}, {31'b0, req_ready}, 32'h1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    int acc;
    int bad;
    acc = 0;
    bad = 0;
    slave_wait   = v.waits;
    slave_prdata = v.prdata;
    slave_err    = v.slverr;
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'h1);
    issue(v.write, v.addr, v.wdata);
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      if (apb_psel) begin
        if (apb_paddr !== v.addr || apb_pwrite !== v.write || apb_pwdata !== v.wdata) bad++;
        if (apb_penable) begin
          acc++;
          if (cyc == 1) bad++;
        end else if (cyc != 1) bad++;
      end else bad++;
      @(posedge clk); #1;
      cyc++;
    end
    if (apb_psel || apb_penable || req_ready) bad++;
    check({tag, "_latency"}, cyc, v.exp_lat);
    check({tag, "_access_cycles"}, acc, v.exp_acc);
    check({tag, "_apb_phase"}, bad, 0);
    check({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
    check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, v.exp_err});
    check({tag, "_timeout"}, {31'b0, rsp_timeout}, {31'b0, v.exp_to});
    handshake(tag);
  endtask

  initial begin
    int cyc;
    int bad;
    int seen;
    int first_cyc;
    int second_cyc;

    vecs[0] = '{1'b0, 12'h004, 32'h0,        0,  32'h0000_00A5, 1'b0, 32'h0000_00A5, 1'b0, 1'b0, 3, 1};
    vecs[1] = '{1'b1, 12'h000, 32'h0000_0055, 3,  32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 1'b0, 6, 4};
    vecs[2] = '{1'b0, 12'hFFC, 32'h0,        0,  32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 3, 1};
    vecs[3] = '{1'b0, 12'h010, 32'h0,        99, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b1, 1'b1, 6, 4};
    vecs[4] = '{1'b1, 12'h7F0, 32'hFFFF_FFFF, 4,  32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 6, 4};
    vecs[5] = '{1'b1, 12'h008, 32'h0000_0001, 1,  32'h5555_5555, 1'b1, 32'h0,         1'b1, 1'b0, 4, 2};
    vecs[6] = '{1'b0, 12'h100, 32'hAAAA_0000, 2,  32'h8000_0001, 1'b0, 32'h8000_0001, 1'b0, 1'b0, 5, 3};

    reset        = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = 12'h0;
    req_wdata    = 32'h0;
    rsp_ready    = 1'b0;
    slave_wait   = 0;
    slave_prdata = 32'h0;
    slave_err    = 1'b0;
    force_pready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'h0);
    check("rst_psel_pen_valid", {29'b0, apb_psel, apb_penable, rsp_valid}, 32'h0);
    check("rst_addr_write", {19'b0, apb_paddr, apb_pwrite}, 32'h0);
    check("rst_pwdata", apb_pwdata, 32'h0);
    check("rst_rsp", {30'b0, rsp_err, rsp_timeout} | rsp_rdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_req_ready", {31'b0, req_ready}, 32'h1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Timeout followed by backpressure and a late pready.
    slave_wait   = 99;
    slave_err    = 1'b0;
    slave_prdata = 32'h0;
    issue(1'b0, 12'h020, 32'h0);
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_latency", cyc, 6);
    force_pready = 1'b1;
    slave_prdata = 32'h1111_1111;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (!rsp_valid || rsp_rdata !== 32'h0 || !rsp_err || !rsp_timeout || req_ready || apb_psel || apb_penable) bad++;
      @(posedge clk); #1;
    end
    check("bp_stable", bad, 0);
    check("bp_still_valid", {31'b0, rsp_valid}, 32'h1);
    force_pready = 1'b0;
    handshake("bp");

    // Back-to-back with rsp_ready tied high.
    slave_wait   = 0;
    slave_prdata = 32'h0000_0077;
    rsp_ready    = 1'b1;
    req_write    = 1'b0;
    req_addr     = 12'h00C;
    req_valid    = 1'b1;
    seen = 0;
    first_cyc = -1;
    second_cyc = -1;
    for (int k = 0; k < 16 && seen < 2; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        seen++;
        if (seen == 1) first_cyc = k;
        else begin
          second_cyc = k;
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check("b2b_count", seen, 2);
    check("b2b_spacing", second_cyc - first_cyc, 4);
    check("b2b_rdata", rsp_rdata, 32'h0000_0077);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    check("b2b_idle", {30'b0, req_ready, rsp_valid}, 32'h2);

    // Reset while in ACCESS.
    slave_wait = 99;
    issue(1'b1, 12'h044, 32'h0000_0099);
    @(posedge clk); #1;
    check("mid_in_access", {30'b0, apb_psel, apb_penable}, 32'h3);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_psel_pen", {30'b0, apb_psel, apb_penable}, 32'h0);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid) seen++;
      @(posedge clk); #1;
    end
    check("mid_no_rsp", seen, 0);
    run_vec(vecs[0], "post_mid_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
